// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   typedef enum logic [2:0] {
      BOOT,
      REQ,
      WAIT,
      HOLD,
      DRAIN,
      FAULT
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive cycles spent waiting on an instruction-memory response
// and flags expiry on the cycle that completes TIMEOUT such cycles.
module fetch_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{clk, reset, clear, enable};
         assign expired = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT + 1);

         logic [CW-1:0] count_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               count_reg <= '0;
            end else if (clear) begin
               count_reg <= '0;
            end else if (enable && !expired) begin
               count_reg <= count_reg + CW'(1);
            end
         end

         // Combinational so the FSM can leave for FAULT on the same edge that
         // would have recorded the TIMEOUT-th idle cycle.
         assign expired = enable && (count_reg == CW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding memory request at a time, holds the
// fetched word for decode, drops stale responses after a redirect.
module if_stage
   import if_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               TIMEOUT  = 64
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             id_ready,
   output logic [31:0]      instruction,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             instr_valid,
   output logic             fetch_fault
);

   fetch_state_t     state_reg, state_next;
   logic [WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
   logic [31:0]      instr_reg, instr_next;
   logic [WIDTH-1:0] pc_out_reg, pc_out_next;
   logic             instr_valid_reg, instr_valid_next;

   logic             wd_clear;
   logic             wd_enable;
   logic             wd_expired;
   logic [WIDTH-1:0] redirect_target;

   assign redirect_target = redirect_pc & ~WIDTH'(3);

   fetch_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= BOOT;
         fetch_pc_reg    <= RESET_PC;
         instr_reg       <= NOP_INSTR;
         pc_out_reg      <= RESET_PC;
         instr_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         fetch_pc_reg    <= fetch_pc_next;
         instr_reg       <= instr_next;
         pc_out_reg      <= pc_out_next;
         instr_valid_reg <= instr_valid_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      fetch_pc_next    = fetch_pc_reg;
      instr_next       = instr_reg;
      pc_out_next      = pc_out_reg;
      instr_valid_next = instr_valid_reg;
      wd_clear         = 1'b0;
      wd_enable        = 1'b0;

      case (state_reg)
         BOOT: begin
            state_next = REQ;
            if (redirect) begin
               fetch_pc_next    = redirect_target;
               instr_valid_next = 1'b0;
            end
         end

         REQ: begin
            wd_clear = imem_gnt;
            if (redirect) begin
               fetch_pc_next    = redirect_target;
               instr_valid_next = 1'b0;
            end
            if (imem_gnt) begin
               state_next = redirect ? DRAIN : WAIT;
            end
         end

         WAIT: begin
            wd_enable = !imem_rvalid;
            if (wd_expired) begin
               state_next = FAULT;
            end else if (redirect) begin
               fetch_pc_next    = redirect_target;
               instr_valid_next = 1'b0;
               state_next       = imem_rvalid ? REQ : DRAIN;
            end else if (imem_rvalid) begin
               instr_next       = imem_rdata;
               pc_out_next      = fetch_pc_reg;
               fetch_pc_next    = fetch_pc_reg + WIDTH'(PC_STEP);
               instr_valid_next = 1'b1;
               state_next       = HOLD;
            end
         end

         DRAIN: begin
            // The response owed to the abandoned request must be swallowed
            // before a new request can be issued.
            wd_enable = !imem_rvalid;
            if (wd_expired) begin
               state_next = FAULT;
            end else begin
               if (redirect) begin
                  fetch_pc_next    = redirect_target;
                  instr_valid_next = 1'b0;
               end
               if (imem_rvalid) begin
                  state_next = REQ;
               end
            end
         end

         HOLD: begin
            if (redirect) begin
               fetch_pc_next    = redirect_target;
               instr_valid_next = 1'b0;
               state_next       = REQ;
            end else if (id_ready) begin
               instr_valid_next = 1'b0;
               state_next       = REQ;
            end
         end

         FAULT: begin
            instr_valid_next = 1'b0;
         end

         default: begin
            state_next = FAULT;
         end
      endcase
   end

   assign imem_req    = (state_reg == REQ);
   assign imem_addr   = fetch_pc_reg;
   assign instruction = instr_reg;
   assign pc_out      = pc_out_reg;
   assign pc_plus4    = pc_out_reg + WIDTH'(PC_STEP);
   assign instr_valid = instr_valid_reg;
   assign fetch_fault = (state_reg == FAULT);

endmodule
